// File: rtl/fetch_queue.sv
// Instruction fetch unit: sequential AXI AR issue with credit-limited outstanding
// requests, a DEPTH-entry {pc, ir, fault} prefetch queue and redirect flushing.

package core;
    localparam logic [31:0] CODE_BASE = 32'h0001_0000;
endpackage

package axi4;
    // Instruction, secure, unprivileged access.
    localparam logic [2:0] AXI4 = 3'b100;
endpackage

module fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = core::CODE_BASE
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       branch,
    input  logic [31:0]                target,
    input  logic                       trap,
    input  logic [31:0]                handler,
    input  logic                       bubble,
    output logic                       arvalid,
    input  logic                       arready,
    output logic [31:0]                araddr,
    output logic [2:0]                 arprot,
    input  logic                       rvalid,
    output logic                       rready,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    output logic                       down_tvalid,
    input  logic                       down_tready,
    output logic [31:0]                down_pc,
    output logic [31:0]                down_ir,
    output logic                       down_fault,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = LW + 1;
    localparam logic [OW-1:0] MAX_O   = OW'(MAX_OUTSTANDING);
    localparam logic [AW-1:0] PC_LAST = AW'(MAX_OUTSTANDING - 1);
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        fault;
    } entry_t;

    entry_t        queue [DEPTH];
    logic [31:0]   pc_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] pc_wr, pc_rd;
    logic [LW-1:0] level_q, level_d;
    logic [OW-1:0] outstanding, outstanding_d, discard, discard_d;
    logic          stale, stale_d;
    logic [31:0]   stale_addr, stale_addr_d;
    logic          arvalid_q, arvalid_d;
    logic [31:0]   araddr_q, araddr_d;
    logic          rready_q;

    logic          redirect, ar_hs, r_hs, push, pop, credit;
    logic [31:0]   redirect_raw, redirect_addr;

    assign redirect      = trap | branch;
    assign redirect_raw  = trap ? handler : target;
    assign redirect_addr = redirect_raw & ~32'h3;
    assign ar_hs         = arvalid_q & arready;
    assign r_hs          = rvalid & rready_q;
    assign push          = r_hs & (discard == '0) & ~redirect;
    assign pop           = down_tvalid & down_tready & ~redirect;

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        outstanding_d = outstanding + OW'(ar_hs) - OW'(r_hs);
        level_d       = redirect ? '0 : level_q + LW'(push) - LW'(pop);
        discard_d     = discard - OW'(r_hs && discard != '0) + OW'(ar_hs && stale);
        stale_d       = stale;
        stale_addr_d  = stale_addr;
        araddr_d      = araddr_q;

        if (redirect) begin
            discard_d    = outstanding_d;
            stale_d      = arvalid_q & ~arready;
            stale_addr_d = redirect_addr;
        end else if (ar_hs) begin
            stale_d = 1'b0;
        end

        if (ar_hs)
            araddr_d = redirect ? redirect_addr : (stale ? stale_addr : araddr_q + 32'd4);
        else if (redirect && !arvalid_q)
            araddr_d = redirect_addr;

        // A pending request already passed the credit check, so it is held until accepted.
        credit    = (outstanding_d < MAX_O) &&
                    (SW'(level_d) + SW'(outstanding_d) < DEPTH_S);
        arvalid_d = (arvalid_q & ~arready) | credit;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arvalid_q   <= 1'b0;
            araddr_q    <= RESET_PC;
            rready_q    <= 1'b0;
            level_q     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pc_wr       <= '0;
            pc_rd       <= '0;
            outstanding <= '0;
            discard     <= '0;
            stale       <= 1'b0;
            stale_addr  <= RESET_PC;
        end else begin
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            rready_q    <= 1'b1;
            level_q     <= level_d;
            outstanding <= outstanding_d;
            discard     <= discard_d;
            stale       <= stale_d;
            stale_addr  <= stale_addr_d;
            if (ar_hs) pc_wr <= (pc_wr == PC_LAST) ? '0 : pc_wr + AW'(1);
            if (r_hs)  pc_rd <= (pc_rd == PC_LAST) ? '0 : pc_rd + AW'(1);
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: storage arrays carry no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge aclk) begin
        if (ar_hs) pc_fifo[pc_wr] <= araddr_q;
        if (push)  queue[wr_ptr]  <= '{pc: pc_fifo[pc_rd], ir: rdata, fault: (rresp != 2'b00)};
    end

    assign arvalid     = arvalid_q;
    assign araddr      = araddr_q;
    assign arprot      = axi4::AXI4;
    assign rready      = rready_q;
    assign level       = level_q;
    assign down_tvalid = (level_q != '0) & ~bubble;
    assign down_pc     = queue[rd_ptr].pc;
    assign down_ir     = queue[rd_ptr].ir;
    assign down_fault  = queue[rd_ptr].fault;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a 1-cycle-latency AXI slave model drives reads,
// and every AR handshake and stream pop is compared against expected addresses.

module tb_fetch_queue;

    localparam logic [31:0] RESET = 32'h0001_0000;

    logic        aclk, aresetn, branch, trap, bubble;
    logic [31:0] target, handler;
    logic        arvalid, arready, rvalid, rready, down_tvalid, down_tready, down_fault;
    logic [31:0] araddr, rdata, down_pc, down_ir;
    logic [2:0]  arprot, level;
    logic [1:0]  rresp;

    fetch_queue dut (
        .aclk(aclk), .aresetn(aresetn), .branch(branch), .target(target),
        .trap(trap), .handler(handler), .bubble(bubble),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .down_tvalid(down_tvalid), .down_tready(down_tready), .down_pc(down_pc),
        .down_ir(down_ir), .down_fault(down_fault), .level(level)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          checks, errors;
    logic [31:0] rq[$];
    logic        ar_en, r_en, stale_m;
    logic [31:0] exp_ar, exp_pc, stale_a, err_addr, last_pop_pc;
    int          out_cnt, max_out, max_level, pops, faults_seen;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic model_reset();
        rq.delete();
        exp_ar = RESET; exp_pc = RESET; stale_m = 1'b0; stale_a = '0;
        out_cnt = 0;
    endtask

    // One clock: drive slave/stream inputs, check handshakes, advance the model.
    task automatic step();
        logic        ar_hs, r_hs, redir;
        logic [31:0] a, addr_now;
        arready = ar_en;
        rvalid  = r_en && (rq.size() > 0);
        rdata   = rvalid ? data_of(rq[0]) : 32'h0;
        rresp   = (rvalid && rq[0] == err_addr) ? 2'b10 : 2'b00;
        #1;
        redir    = branch | trap;
        a        = (trap ? handler : target) & ~32'h3;
        ar_hs    = arvalid & arready;
        r_hs     = rvalid & rready;
        addr_now = araddr;
        if (ar_hs) begin
            checks++;
            if (araddr !== exp_ar) begin
                errors++;
                $display("FAIL ar_addr: got %h expected %h", araddr, exp_ar);
            end
            exp_ar  = redir ? a : (stale_m ? stale_a : exp_ar + 32'd4);
            stale_m = 1'b0;
        end else if (redir) begin
            if (arvalid) begin stale_m = 1'b1; stale_a = a; end
            else exp_ar = a;
        end
        if (down_tvalid && down_tready && !redir) begin
            checks += 3;
            if (down_pc !== exp_pc) begin
                errors++; $display("FAIL pop_pc: got %h expected %h", down_pc, exp_pc);
            end
            if (down_ir !== data_of(exp_pc)) begin
                errors++; $display("FAIL pop_ir: got %h expected %h", down_ir, data_of(exp_pc));
            end
            if (down_fault !== (exp_pc == err_addr)) begin
                errors++; $display("FAIL pop_fault: got %b expected %b", down_fault, exp_pc == err_addr);
            end
            last_pop_pc = down_pc;
            pops++;
            if (down_fault) faults_seen++;
            exp_pc += 32'd4;
        end
        if (redir) exp_pc = a;
        if (int'(level) > max_level) max_level = int'(level);
        @(posedge aclk); #1;
        if (ar_hs) rq.push_back(addr_now);
        if (r_hs && rq.size() > 0) void'(rq.pop_front());
        out_cnt += int'(ar_hs) - int'(r_hs);
        if (out_cnt > max_out) max_out = out_cnt;
        branch = 1'b0;
        trap   = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_pop(input logic [31:0] want, input string name);
        int p0 = pops;
        for (int i = 0; i < 50 && pops == p0; i++) step();
        checks++;
        if (pops == p0) begin
            errors++; $display("FAIL %s: no pop within budget, expected pc %h", name, want);
        end else if (last_pop_pc !== want) begin
            errors++; $display("FAIL %s: first pc %h expected %h", name, last_pop_pc, want);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (arvalid !== 1'b0 || araddr !== RESET || rready !== 1'b0 ||
            down_tvalid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL %s: arvalid=%b araddr=%h rready=%b tvalid=%b level=%0d, expected 0/%h/0/0/0",
                     name, arvalid, araddr, rready, down_tvalid, level, RESET);
        end
        checks++;
        if (arprot !== 3'b100) begin
            errors++; $display("FAIL %s_arprot: got %b expected 100", name, arprot);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; branch = 0; trap = 0; bubble = 0; target = '0; handler = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; down_tready = 0;
        ar_en = 0; r_en = 0; err_addr = 32'hFFFF_FFFF;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_stream();
        int p0;
        ar_en = 1; r_en = 1; down_tready = 1;
        p0 = pops;
        run(30);
        checks++;
        if (pops - p0 < 10) begin
            errors++; $display("FAIL stream_count: got %0d pops expected >= 10", pops - p0);
        end
        checks++;
        if (max_out > 2) begin
            errors++; $display("FAIL stream_outstanding: got %0d expected <= 2", max_out);
        end
    endtask

    task automatic test_backpressure_bubble();
        down_tready = 0;
        run(20);
        checks++;
        if (level !== 3'd4 || arvalid !== 1'b0) begin
            errors++; $display("FAIL backpressure: level=%0d arvalid=%b expected 4/0", level, arvalid);
        end
        bubble = 1; down_tready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (down_tvalid !== 1'b0 || level !== 3'd4) begin
                errors++; $display("FAIL bubble: tvalid=%b level=%0d expected 0/4", down_tvalid, level);
            end
        end
        bubble = 0;
        run(20);
        checks++;
        if (max_level != 4) begin
            errors++; $display("FAIL max_level: got %0d expected 4", max_level);
        end
    endtask

    task automatic test_branch();
        r_en = 0;
        run(6);
        checks++;
        if (out_cnt != 2) begin
            errors++; $display("FAIL branch_outstanding: got %0d expected 2", out_cnt);
        end
        branch = 1; target = 32'h0000_1002;
        step();
        checks++;
        if (araddr !== 32'h0000_1000) begin
            errors++; $display("FAIL branch_araddr: got %h expected 00001000", araddr);
        end
        r_en = 1;
        run_until_pop(32'h0000_1000, "branch_first_pc");
        run(10);
    endtask

    task automatic test_trap_priority();
        trap = 1; handler = 32'h0000_0100; branch = 1; target = 32'h0000_0200;
        step();
        run_until_pop(32'h0000_0100, "trap_priority");
        run(6);
    endtask

    task automatic test_stale();
        logic [31:0] pend;
        ar_en = 0;
        for (int i = 0; i < 20 && !arvalid; i++) step();
        checks++;
        if (!arvalid) begin
            errors++; $display("FAIL stale_wait: arvalid=%b expected 1", arvalid);
        end
        pend = araddr;
        branch = 1; target = 32'h0000_3000;
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (arvalid !== 1'b1 || araddr !== pend) begin
                errors++; $display("FAIL stale_hold: arvalid=%b araddr=%h expected 1/%h", arvalid, araddr, pend);
            end
            step();
        end
        ar_en = 1;
        step();
        checks++;
        if (araddr !== 32'h0000_3000) begin
            errors++; $display("FAIL stale_reload: got %h expected 00003000", araddr);
        end
        run_until_pop(32'h0000_3000, "stale_first_pc");
        run(6);
    endtask

    task automatic test_fault();
        int f0 = faults_seen;
        err_addr = 32'h0000_4008;
        branch = 1; target = 32'h0000_4000;
        step();
        run(20);
        checks++;
        if (faults_seen - f0 != 1) begin
            errors++; $display("FAIL fault_count: got %0d expected 1", faults_seen - f0);
        end
        err_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_async_reset();
        run(5);
        #2 aresetn = 1'b0;
        rvalid = 0; arready = 0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk); #1;
        run_until_pop(RESET, "after_reset_pc");
        run(5);
    endtask

    initial begin
        checks = 0; errors = 0; max_out = 0; max_level = 0; pops = 0; faults_seen = 0;
        last_pop_pc = '0;
        test_reset();
        test_stream();
        test_backpressure_bubble();
        test_branch();
        test_trap_priority();
        test_stale();
        test_fault();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction fetch unit with a prefetch queue and multiple outstanding AXI read requests. It issues sequential fetch addresses to the instruction cache AXI read channel and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It drives the decode stage over a valid/ready stream. Branch and trap redirects flush the queue and discard in-flight responses.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered read requests; 1..DEPTH
RESET_PC, core::CODE_BASE, first fetch address after reset; bits [1:0] must be 0

Ports:
aclk  in  1  clock; all state updates on the rising edge
aresetn  in  1  asynchronous active-low reset
branch  in  1  redirect to target (single-cycle pulse)
target  in  32  branch target; bits [1:0] ignored
trap  in  1  redirect to handler; has priority over branch
handler  in  32  trap handler address; bits [1:0] ignored
bubble  in  1  holds the output stream invalid while high
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
araddr  out  32  AXI AR address
arprot  out  3  constant axi4::AXI4
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rdata  in  32  instruction word
rresp  in  2  AXI response; non-OKAY marks a fault
down_tvalid  out  1  stream valid
down_tready  in  1  stream ready
down_pc  out  32  PC of head entry
down_ir  out  32  instruction of head entry
down_fault  out  1  head entry returned a non-OKAY rresp
level  out  log2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset values: arvalid=0, araddr=RESET_PC, rready=0, down_tvalid=0, level=0. Outstanding count, discard count and stale flag are 0. Reset may assert at any cycle. Any transaction in flight when reset asserts is abandoned; the AXI slave is reset by the same aresetn.
- araddr[1:0] is always 00. An AR handshake occurs when arvalid & arready. After a handshake, araddr increments by 4 (mod 2^32).
- Credit rule: arvalid is registered. It is 1 in cycle N+1 when, after cycle-N updates, outstanding < MAX_OUTSTANDING and level + outstanding < DEPTH. Otherwise it is 0.
- AXI stability: while arvalid & ~arready, araddr and arvalid stay constant, including across a redirect.
- rready = 1 from the first clock after reset release. Credits guarantee that queue space always exists for every response.
- R handshake (rvalid & rready):
  - If the discard count > 0, the response is dropped and the discard count decrements.
  - Otherwise {pc, rdata, rresp!=OKAY} is written at the tail. The pc is the address of the oldest outstanding request, held in an internal MAX_OUTSTANDING-deep address FIFO.
- Output: down_tvalid = (level != 0) & ~bubble. A pop occurs on down_tvalid & down_tready.
- Latency: no bypass. A response written at edge N is visible on the stream after edge N.
- Simultaneous push and pop leave level unchanged. level never exceeds DEPTH. A pop with the queue empty cannot occur.
- Redirect (trap | branch) in cycle N, with redirect address A = trap ? handler : target, and bits [1:0] cleared:
  - Queue flushed; level=0 after edge N, and any pop or push in cycle N is cancelled.
  - A response arriving in cycle N is dropped.
  - Discard count becomes the number of requests outstanding after edge N (including one accepted in cycle N), excluding any response dropped in cycle N.
  - If no AR is pending unaccepted after edge N, araddr=A and the next request issues per the credit rule.
  - If an AR was pending unaccepted (arvalid & ~arready in cycle N), the stale flag is set. The pending request stays unchanged and counts toward discard when accepted. On its acceptance, araddr loads A instead of +4.
  - A redirect in consecutive cycles: the last one wins, and all earlier in-flight responses are discarded.
- Outstanding count is incremented on each AR handshake and decremented on each R handshake. Both in the same cycle leave it unchanged.

Test Plan:
- Reset release, arready=rvalid=1, 1-cycle slave latency, down_tready=1 -> AR addresses RESET_PC, +4, +8...; stream pcs in the same order; ir equals slave data; never more than MAX_OUTSTANDING=2 outstanding.
- down_tready=0 for 20 cycles -> level saturates at 4, arvalid falls, no data lost; on release, pcs continue contiguously with no gap.
- Branch to 0x0000_1002 with 2 responses outstanding -> next araddr=0x0000_1000; both old responses dropped; first stream pc after the branch = 0x1000.
- Trap and branch in the same cycle, handler=0x100, target=0x200 -> next fetch 0x100.
- Branch while arvalid high and arready held low for 3 cycles -> araddr unchanged until accept; that response is discarded; then araddr=target.
- rresp=SLVERR on the 3rd fetch -> that entry has down_fault=1 and the others 0. bubble=1 holds down_tvalid=0 with level unchanged. aresetn pulsed mid-stream -> all outputs return to reset values asynchronously.
